result_uart_tx: RTL and testbench
=================================

# result_uart_tx

Downstream stage of the 2x2 matrix-multiplier wrapper on the FPGA build. It captures the packed 20-bit product (four 5-bit elements) when the wrapper pulses its valid strobe, then serialises it to the host as a 5-byte UART 8N1 frame: header 0xA5 followed by c00, c01, c10, c11. It reports busy/done status and a sticky overrun flag for results that arrive while a frame is still in flight.

## Interface
- CLKS_PER_BIT, default 868: clock cycles per UART bit (100 MHz / 115200 baud); legal range ≥ 2.
- HEADER, default 8'hA5: first byte of every frame.
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- valid_in  input  1  one-cycle strobe from the multiplier wrapper; result_in is valid in the same cycle.
- result_in  input  20  packed result: [4:0]=c00, [9:5]=c01, [14:10]=c10, [19:15]=c11.
- tx  output  1  UART serial line; idle high.
- busy  output  1  high while a frame is being transmitted.
- done  output  1  one-cycle pulse when the last stop bit of a frame completes.
- overrun  output  1  sticky; set when valid_in arrives while busy. Cleared only by rst.

## Operation
- Reset values: tx=1, busy=0, done=0, overrun=0, FSM=IDLE, all counters=0.
- All outputs are registered.
- Capture: when valid_in=1 and busy=0, latch result_in into a 20-bit holding register, set byte index=0, and go to START. busy=1 from the next cycle.
- Byte i of the frame:
  - i=0: HEADER.
  - i=1..4: {3'b000, result[5(i-1)+4 : 5(i-1)]}, i.e. zero-extended elements in the order c00, c01, c10, c11.
- FSM states:
  - IDLE: tx=1. Waits for valid_in.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. A 3-bit bit index tracks position. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then:
    - byte index <4: increment it and go to START. No extra idle between bytes.
    - byte index =4: go to IDLE, busy←0, done←1.
- Baud counter: width $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and reloads to 0 on every bit boundary, so no drift accumulates.
- valid_in while busy=1: the strobe is ignored, overrun←1, and the holding register and the frame in progress are unaffected.
- valid_in in the done cycle: busy is already 0, so the strobe is accepted and the new frame's start bit follows immediately.
- rst mid-frame: at the next edge all state returns to reset values, the partial frame is abandoned, and tx returns high.

## Timing
- Let E0 be the edge at which valid_in is sampled with busy=0.
- Start bit of byte 0: tx is low from E0 to E0+CLKS_PER_BIT.
- Bit k of byte i occupies the window [E0 + (10i+k)·CLKS_PER_BIT, E0 + (10i+k+1)·CLKS_PER_BIT). Here k=0 is the start bit, k=1..8 are data bits, and k=9 is the stop bit.
- Frame length: exactly 50·CLKS_PER_BIT cycles.
- At edge E0+50·CLKS_PER_BIT: busy falls and done rises. done is high for exactly one cycle.
- busy is high from E0 to E0+50·CLKS_PER_BIT.
- Capture-to-tx latency: one edge (tx falls at E0).

## Test plan
Use CLKS_PER_BIT=4 for all scenarios.

- Nominal frame: result_in=20'h20C41 (c00=1, c01=2, c10=3, c11=4), 1-cycle valid_in. Required: decoded bytes A5,01,02,03,04; done at E0+200; busy high for exactly 200 cycles.
- Maximum values: result_in=20'hFFFFF. Required: bytes A5,1F,1F,1F,1F; the upper 3 data bits of each element byte are 0.
- Overrun: second valid_in at E0+10 with result_in=20'h00000. Required: overrun=1 from E0+11 onward; frame is still A5,01,02,03,04; no second frame follows.
- Back-to-back: drive valid_in during the done cycle with result_in=20'h00421 (c00=1, c01=1, c10=1, c11=0). Required: start bit begins at the next edge; second frame is A5,01,01,01,00; overrun stays 0.
- Reset mid-frame: assert rst for 1 cycle at E0+60. Required: next edge gives tx=1, busy=0, overrun=0, done=0. A following valid_in with 20'h20C41 produces a complete, correct frame.
- Idle check: no valid_in for 500 cycles after reset. Required: tx=1, busy=0, done never pulses.

Source files
------------

// File: rtl/result_uart_tx.sv
// Serialises a captured 2x2 matrix-multiplier result as a 5-byte UART 8N1 frame:
// a header byte followed by the four zero-extended 5-bit elements c00, c01, c10, c11.
module result_uart_tx #(
  parameter int         CLKS_PER_BIT = 868,
  parameter logic [7:0] HEADER       = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [19:0] result_in,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

  localparam int               CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BYTE = 3'd4;
  localparam logic [2:0]       LAST_BIT  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t           state_r, state_next_s;
  logic [CNT_W-1:0] baud_cnt_r, baud_cnt_next_s;
  logic [2:0]       bit_idx_r, bit_idx_next_s;
  logic [2:0]       byte_idx_r, byte_idx_next_s;
  logic [19:0]      hold_r, hold_next_s;
  logic             tx_r, tx_next_s;
  logic             busy_r, busy_next_s;
  logic             done_r, done_next_s;
  logic             overrun_r, overrun_next_s;
  logic             bit_end_s;
  logic [7:0]       tx_byte_s;

  function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [19:0] res);
    logic [7:0] b;
    case (idx)
      3'd0:    b = HEADER;
      3'd1:    b = {3'b000, res[4:0]};
      3'd2:    b = {3'b000, res[9:5]};
      3'd3:    b = {3'b000, res[14:10]};
      3'd4:    b = {3'b000, res[19:15]};
      default: b = 8'hFF;
    endcase
    return b;
  endfunction

  assign bit_end_s = (baud_cnt_r == CNT_LAST);

  // Next-state, counters and next registered output values.
  always_comb begin
    state_next_s    = state_r;
    baud_cnt_next_s = baud_cnt_r;
    bit_idx_next_s  = bit_idx_r;
    byte_idx_next_s = byte_idx_r;
    hold_next_s     = hold_r;
    busy_next_s     = busy_r;
    done_next_s     = 1'b0;
    overrun_next_s  = overrun_r | (valid_in & busy_r);

    case (state_r)
      ST_IDLE: begin
        if (valid_in) begin
          hold_next_s     = result_in;
          byte_idx_next_s = 3'd0;
          bit_idx_next_s  = 3'd0;
          baud_cnt_next_s = '0;
          busy_next_s     = 1'b1;
          state_next_s    = ST_START;
        end else begin
          state_next_s    = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          baud_cnt_next_s = '0;
          bit_idx_next_s  = 3'd0;
          state_next_s    = ST_DATA;
        end else begin
          baud_cnt_next_s = baud_cnt_r + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          baud_cnt_next_s = '0;
          if (bit_idx_r == LAST_BIT) begin
            state_next_s   = ST_STOP;
          end else begin
            bit_idx_next_s = bit_idx_r + 3'd1;
          end
        end else begin
          baud_cnt_next_s = baud_cnt_r + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (bit_end_s) begin
          baud_cnt_next_s = '0;
          if (byte_idx_r == LAST_BYTE) begin
            state_next_s    = ST_IDLE;
            busy_next_s     = 1'b0;
            done_next_s     = 1'b1;
          end else begin
            byte_idx_next_s = byte_idx_r + 3'd1;
            state_next_s    = ST_START;
          end
        end else begin
          baud_cnt_next_s = baud_cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        busy_next_s  = 1'b0;
      end
    endcase

    // The line level is derived from the upcoming state so tx stays registered.
    tx_byte_s = frame_byte(byte_idx_next_s, hold_next_s);
    case (state_next_s)
      ST_IDLE:  tx_next_s = 1'b1;
      ST_START: tx_next_s = 1'b0;
      ST_DATA:  tx_next_s = tx_byte_s[bit_idx_next_s];
      ST_STOP:  tx_next_s = 1'b1;
      default:  tx_next_s = 1'b1;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      baud_cnt_r <= '0;
      bit_idx_r  <= 3'd0;
      byte_idx_r <= 3'd0;
      hold_r     <= 20'h00000;
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      baud_cnt_r <= baud_cnt_next_s;
      bit_idx_r  <= bit_idx_next_s;
      byte_idx_r <= byte_idx_next_s;
      hold_r     <= hold_next_s;
      tx_r       <= tx_next_s;
      busy_r     <= busy_next_s;
      done_r     <= done_next_s;
      overrun_r  <= overrun_next_s;
    end
  end

  assign tx      = tx_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign overrun = overrun_r;

endmodule

// File: tb/tb_result_uart_tx.sv
// Self-checking bench for result_uart_tx: frames are compared against a bit-window
// model of the UART line built directly from the frame layout.
module tb_result_uart_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 50 * CPB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic [19:0] result_in = 20'h00000;
  logic        tx, busy, done, overrun;
  int          checks = 0;
  int          passed = 0;

  always #5 clk = ~clk;

  result_uart_tx #(.CLKS_PER_BIT(CPB), .HEADER(8'hA5)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .result_in(result_in),
    .tx(tx), .busy(busy), .done(done), .overrun(overrun)
  );

  function automatic logic [7:0] model_byte(input logic [19:0] res, input int i);
    if (i == 0) return 8'hA5;
    return 8'((res >> (5 * (i - 1))) & 20'h0001F);
  endfunction

  // Line level in the window t cycles after the capture edge.
  function automatic logic model_tx(input logic [19:0] res, input int t);
    int n, i, k;
    logic [7:0] b;
    n = t / CPB;
    i = n / 10;
    k = n % 10;
    b = model_byte(res, i);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    valid_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic start_frame(input logic [19:0] r);
    @(negedge clk);
    valid_in  = 1'b1;
    result_in = r;
  endtask

  // Observes one frame from its capture edge; optionally injects a strobe at ovr_at
  // or a new strobe in the done cycle. Returns observations only.
  task automatic watch_frame(input logic [19:0] res, input int ovr_at,
                             input logic next_go, input logic [19:0] next_res,
                             output logic [39:0] got, output int wave_err,
                             output int busy_err, output int ovr_err,
                             output logic busy_end, output logic done_end,
                             output logic done_after);
    int n;
    got = '0; wave_err = 0; busy_err = 0; ovr_err = 0;
    for (int t = 0; t < FRAME; t++) begin
      @(negedge clk);
      valid_in = 1'b0;
      if (tx !== model_tx(res, t)) wave_err++;
      if (busy !== 1'b1 || done !== 1'b0) busy_err++;
      if (ovr_at >= 0) begin
        if (t < ovr_at && overrun !== 1'b0) ovr_err++;
        if (t > ovr_at && overrun !== 1'b1) ovr_err++;
      end else if (overrun !== 1'b0) begin
        ovr_err++;
      end
      n = t / CPB;
      if (t % CPB == CPB / 2 && n % 10 >= 1 && n % 10 <= 8) got[8 * (n / 10) + n % 10 - 1] = tx;
      if (ovr_at >= 1 && t == ovr_at - 1) begin
        valid_in  = 1'b1;
        result_in = 20'h00000;
      end
    end
    @(negedge clk);
    busy_end = busy;
    done_end = done;
    if (next_go) begin
      valid_in   = 1'b1;
      result_in  = next_res;
      done_after = 1'b0;
    end else begin
      @(negedge clk);
      done_after = done;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (tx !== 1'b1) $display("FAIL reset_tx got %b exp 1", tx); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else passed++;
    checks++; if (overrun !== 1'b0) $display("FAIL reset_overrun got %b exp 0", overrun); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_idle();
    int tx_err = 0, busy_err = 0, done_err = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) tx_err++;
      if (busy !== 1'b0) busy_err++;
      if (done !== 1'b0) done_err++;
    end
    checks++; if (tx_err != 0) $display("FAIL idle_tx low_cycles %0d exp 0", tx_err); else passed++;
    checks++; if (busy_err != 0) $display("FAIL idle_busy high_cycles %0d exp 0", busy_err); else passed++;
    checks++; if (done_err != 0) $display("FAIL idle_done pulses %0d exp 0", done_err); else passed++;
  endtask

  task automatic test_frame(input string name, input logic [19:0] r);
    logic [39:0] got; int we, be, oe; logic bend, dend, dafter; logic [7:0] exp_b;
    start_frame(r);
    watch_frame(r, -1, 1'b0, 20'h0, got, we, be, oe, bend, dend, dafter);
    for (int i = 0; i < 5; i++) begin
      exp_b = model_byte(r, i);
      checks++;
      if (got[8*i +: 8] !== exp_b) $display("FAIL %s_byte%0d got %02h exp %02h", name, i, got[8*i +: 8], exp_b);
      else passed++;
    end
    checks++; if (we != 0) $display("FAIL %s_wave bad_cycles %0d exp 0", name, we); else passed++;
    checks++; if (be != 0) $display("FAIL %s_busy_window bad_cycles %0d exp 0", name, be); else passed++;
    checks++; if (oe != 0) $display("FAIL %s_overrun bad_cycles %0d exp 0", name, oe); else passed++;
    checks++; if (bend !== 1'b0 || dend !== 1'b1) $display("FAIL %s_end busy=%b done=%b exp busy=0 done=1", name, bend, dend); else passed++;
    checks++; if (dafter !== 1'b0) $display("FAIL %s_done_width got %b exp 0", name, dafter); else passed++;
  endtask

  task automatic test_overrun();
    logic [39:0] got; int we, be, oe, extra; logic bend, dend, dafter;
    do_reset();
    start_frame(20'h20C41);
    watch_frame(20'h20C41, 10, 1'b0, 20'h0, got, we, be, oe, bend, dend, dafter);
    checks++; if (got !== 40'h04030201A5) $display("FAIL ovr_bytes got %010h exp 04030201a5", got); else passed++;
    checks++; if (we != 0) $display("FAIL ovr_wave bad_cycles %0d exp 0", we); else passed++;
    checks++; if (oe != 0) $display("FAIL ovr_flag bad_cycles %0d exp 0", oe); else passed++;
    checks++; if (dend !== 1'b1) $display("FAIL ovr_done got %b exp 1", dend); else passed++;
    extra = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) extra++;
    end
    checks++; if (extra != 0) $display("FAIL ovr_second_frame active_cycles %0d exp 0", extra); else passed++;
    checks++; if (overrun !== 1'b1) $display("FAIL ovr_sticky got %b exp 1", overrun); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [39:0] got; int we, be, oe; logic bend, dend, dafter;
    do_reset();
    start_frame(20'h20C41);
    watch_frame(20'h20C41, -1, 1'b1, 20'h00421, got, we, be, oe, bend, dend, dafter);
    checks++; if (got !== 40'h04030201A5) $display("FAIL b2b_first got %010h exp 04030201a5", got); else passed++;
    checks++; if (dend !== 1'b1) $display("FAIL b2b_done got %b exp 1", dend); else passed++;
    watch_frame(20'h00421, -1, 1'b0, 20'h0, got, we, be, oe, bend, dend, dafter);
    checks++; if (got !== 40'h00010101A5) $display("FAIL b2b_second got %010h exp 00010101a5", got); else passed++;
    checks++; if (we != 0) $display("FAIL b2b_wave bad_cycles %0d exp 0", we); else passed++;
    checks++; if (be != 0) $display("FAIL b2b_busy bad_cycles %0d exp 0", be); else passed++;
    checks++; if (oe != 0 || overrun !== 1'b0) $display("FAIL b2b_overrun bad_cycles %0d flag %b exp 0", oe, overrun); else passed++;
  endtask

  task automatic test_reset_mid();
    logic [39:0] got; int we, be, oe; logic bend, dend, dafter;
    do_reset();
    start_frame(20'h20C41);
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      valid_in = 1'b0;
      if (t == 19) begin
        valid_in  = 1'b1;
        result_in = 20'h00000;
      end
    end
    checks++; if (overrun !== 1'b1) $display("FAIL rstmid_pre_overrun got %b exp 1", overrun); else passed++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || overrun !== 1'b0)
      $display("FAIL rstmid_state got tx=%b busy=%b done=%b ovr=%b exp 1 0 0 0", tx, busy, done, overrun);
    else passed++;
    start_frame(20'h20C41);
    watch_frame(20'h20C41, -1, 1'b0, 20'h0, got, we, be, oe, bend, dend, dafter);
    checks++; if (got !== 40'h04030201A5) $display("FAIL rstmid_frame got %010h exp 04030201a5", got); else passed++;
    checks++; if (we != 0 || be != 0) $display("FAIL rstmid_timing wave %0d busy %0d exp 0 0", we, be); else passed++;
    checks++; if (dend !== 1'b1) $display("FAIL rstmid_done got %b exp 1", dend); else passed++;
  endtask

  task automatic test_random();
    logic [19:0] r;
    for (int n = 0; n < 4; n++) begin
      repeat ($urandom_range(1, 8)) @(negedge clk);
      r = 20'($urandom);
      test_frame("rand", r);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_frame("nominal", 20'h20C41);
    test_frame("maxval", 20'hFFFFF);
    test_random();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
